hazard_detection_unit: RTL and testbench

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

---
 rtl/hazard_detection_unit_if.sv | 25 ++
 rtl/hazard_detection_unit.sv | 116 +++++++++++
 tb/tb_hazard_detection_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_detection_unit_if.sv
// ID-stage hazard query and the hazard unit's stall/forwarding answer.
// The pipeline drives the master side; the hazard unit is the slave.
interface hazard_detection_unit_if;
  logic        ID_VALID;
  logic [4:0]  ID_RS1;
  logic [4:0]  ID_RS2;
  logic [4:0]  ID_RD;
  logic        ID_REG_WRITE_EN;
  logic        ID_MEM_READ;
  logic        FLUSH;
  logic        STALL;
  logic [1:0]  MEM_FORWARD_EN;
  logic [1:0]  WB_FORWARD_EN;
  logic [15:0] STALL_COUNT;

  modport master (
    output ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_REG_WRITE_EN, ID_MEM_READ, FLUSH,
    input  STALL, MEM_FORWARD_EN, WB_FORWARD_EN, STALL_COUNT
  );

  modport slave (
    input  ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_REG_WRITE_EN, ID_MEM_READ, FLUSH,
    output STALL, MEM_FORWARD_EN, WB_FORWARD_EN, STALL_COUNT
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use stall and EX/MEM, MEM/WB forwarding selection for a 5-stage pipeline.
// Tracks EX/MEM/WB destination records and registers forwarding for the instruction entering EX.
module hazard_detection_unit (
  input  logic                   CLK,
  input  logic                   RESET,
  hazard_detection_unit_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       mem_read;
  } stage_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam stage_t STAGE_BUBBLE = '0;
  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  stage_t      stage_q [3];
  stage_t      stage_d [3];
  state_t      state_q, state_d;
  logic [1:0]  mem_fwd_q, mem_fwd_d;
  logic [1:0]  wb_fwd_q, wb_fwd_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use_s;
  logic        stall_s;
  logic        load_ex_s;

  function automatic logic producer_hit(input stage_t s, input logic [4:0] rs);
    return s.valid & s.we & (s.rd != 5'd0) & (s.rd == rs);
  endfunction

  // Load in EX feeding either ID source operand
  always_comb begin
    load_use_s = bus.ID_VALID & stage_q[EX].valid & stage_q[EX].mem_read &
                 (stage_q[EX].rd != 5'd0) &
                 ((stage_q[EX].rd == bus.ID_RS1) | (stage_q[EX].rd == bus.ID_RS2));
  end

  // Stall FSM; FLUSH and reset suppress the stall, which also keeps the next state at RUN
  always_comb begin
    state_d = state_q;
    stall_s = 1'b0;
    case (state_q)
      RUN: begin
        stall_s = load_use_s & ~bus.FLUSH & RESET;
        if (stall_s) begin
          state_d = BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Next stage records, forwarding selects for the instruction entering EX, stall counter
  always_comb begin
    load_ex_s    = bus.ID_VALID & ~stall_s & ~bus.FLUSH;
    stage_d[EX]  = STAGE_BUBBLE;
    stage_d[MEM] = stage_q[EX];
    stage_d[WB]  = stage_q[MEM];
    mem_fwd_d    = 2'b00;
    wb_fwd_d     = 2'b00;
    if (load_ex_s) begin
      stage_d[EX] = '{valid: 1'b1, rd: bus.ID_RD, we: bus.ID_REG_WRITE_EN,
                      mem_read: bus.ID_MEM_READ};
      // A load in EX has no result yet; the stall path covers it instead
      mem_fwd_d[0] = producer_hit(stage_q[EX], bus.ID_RS1) & ~stage_q[EX].mem_read;
      mem_fwd_d[1] = producer_hit(stage_q[EX], bus.ID_RS2) & ~stage_q[EX].mem_read;
      wb_fwd_d[0]  = producer_hit(stage_q[MEM], bus.ID_RS1) & ~mem_fwd_d[0];
      wb_fwd_d[1]  = producer_hit(stage_q[MEM], bus.ID_RS2) & ~mem_fwd_d[1];
    end else begin
      mem_fwd_d = 2'b00;
      wb_fwd_d  = 2'b00;
    end
    if (stall_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 3; i++) begin
        stage_q[i] <= STAGE_BUBBLE;
      end
      state_q       <= RUN;
      mem_fwd_q     <= 2'b00;
      wb_fwd_q      <= 2'b00;
      stall_count_q <= 16'd0;
    end else begin
      stage_q       <= stage_d;
      state_q       <= state_d;
      mem_fwd_q     <= mem_fwd_d;
      wb_fwd_q      <= wb_fwd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.STALL          = stall_s;
  assign bus.MEM_FORWARD_EN = mem_fwd_q;
  assign bus.WB_FORWARD_EN  = wb_fwd_q;
  assign bus.STALL_COUNT    = stall_count_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench: directed pipeline scenarios plus random instruction streams,
// compared against an instruction-history model of the hazard rules.
module tb_hazard_detection_unit;

  logic CLK = 1'b0;
  logic RESET;

  hazard_detection_unit_if bus ();

  hazard_detection_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit load;
  } ins_t;

  // hist[0] is the instruction issued last cycle (in EX), hist[1] the one before (in MEM)
  ins_t     hist[$];
  ins_t     nop;
  bit       m_bubble;
  int       m_cnt;
  bit [1:0] m_mem;
  bit [1:0] m_wb;
  int       checks = 0;
  int       errors = 0;
  logic     obs_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes(input ins_t p, input int r);
    return p.valid && p.we && (p.rd != 0) && (p.rd == r);
  endfunction

  // One clock: drive ID inputs, check STALL mid-cycle, advance model, check registered outputs
  task automatic cycle(input bit idv, input int rs1, input int rs2, input int rd,
                       input bit we, input bit ld, input bit fl, input bit rst);
    int       src[2];
    bit       exp_stall;
    bit       loaded;
    bit [1:0] nm;
    bit [1:0] nw;
    ins_t     ex;
    ins_t     issued;
    logic [4:0] r1, r2, rdv;
    r1  = rs1[4:0];
    r2  = rs2[4:0];
    rdv = rd[4:0];
    bus.ID_VALID        = idv;
    bus.ID_RS1          = r1;
    bus.ID_RS2          = r2;
    bus.ID_RD           = rdv;
    bus.ID_REG_WRITE_EN = we;
    bus.ID_MEM_READ     = ld;
    bus.FLUSH           = fl;
    RESET               = rst;
    src[0] = rs1;
    src[1] = rs2;
    ex = hist[0];
    exp_stall = rst && !m_bubble && idv && ex.valid && ex.load && (ex.rd != 0) &&
                ((ex.rd == rs1) || (ex.rd == rs2)) && !fl;
    @(negedge CLK);
    obs_stall = bus.STALL;
    check_eq("stall", {31'd0, bus.STALL}, {31'd0, exp_stall});
    loaded = idv && !exp_stall && !fl;
    nm = 2'b00;
    nw = 2'b00;
    if (loaded) begin
      for (int i = 0; i < 2; i++) begin
        if (writes(hist[0], src[i])) begin
          nm[i] = !hist[0].load;
        end else if (writes(hist[1], src[i])) begin
          nw[i] = 1'b1;
        end
      end
    end
    if (!rst) begin
      hist     = {nop, nop};
      m_bubble = 1'b0;
      m_mem    = 2'b00;
      m_wb     = 2'b00;
      m_cnt    = 0;
    end else begin
      m_mem    = nm;
      m_wb     = nw;
      m_bubble = exp_stall;
      if (exp_stall && m_cnt < 65535) m_cnt++;
      issued = loaded ? '{valid: 1'b1, rd: rd, we: we, load: ld} : nop;
      hist.push_front(issued);
      while (hist.size() > 2) void'(hist.pop_back());
    end
    @(posedge CLK);
    #1;
    check_eq("mem_fwd", {30'd0, bus.MEM_FORWARD_EN}, {30'd0, m_mem});
    check_eq("wb_fwd", {30'd0, bus.WB_FORWARD_EN}, {30'd0, m_wb});
    check_eq("stall_count", {16'd0, bus.STALL_COUNT}, m_cnt);
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nop      = '{valid: 1'b0, rd: 0, we: 1'b0, load: 1'b0};
    hist     = {nop, nop};
    m_bubble = 1'b0;
    m_cnt    = 0;
    m_mem    = 2'b00;
    m_wb     = 2'b00;
    bus.ID_VALID = 1'b0; bus.ID_RS1 = 5'd0; bus.ID_RS2 = 5'd0; bus.ID_RD = 5'd0;
    bus.ID_REG_WRITE_EN = 1'b0; bus.ID_MEM_READ = 1'b0; bus.FLUSH = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    check_eq("reset_mem", {30'd0, bus.MEM_FORWARD_EN}, 32'd0);
    check_eq("reset_cnt", {16'd0, bus.STALL_COUNT}, 32'd0);

    // EX/MEM forward to rs1
    cycle(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 5, 6, 9, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("add_mem", {30'd0, bus.MEM_FORWARD_EN}, 32'd1);
    check_eq("add_wb", {30'd0, bus.WB_FORWARD_EN}, 32'd0);

    // MEM/WB forward to both operands
    do_reset();
    cycle(1'b1, 0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7, 7, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("wb_both", {30'd0, bus.WB_FORWARD_EN}, 32'd3);
    check_eq("wb_both_mem", {30'd0, bus.MEM_FORWARD_EN}, 32'd0);

    // Load-use: one stall, then the held instruction forwards from MEM/WB
    do_reset();
    cycle(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1, 8, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("lu_stall", {31'd0, obs_stall}, 32'd1);
    check_eq("lu_count", {16'd0, bus.STALL_COUNT}, 32'd1);
    cycle(1'b1, 1, 8, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("lu_release", {31'd0, obs_stall}, 32'd0);
    check_eq("lu_wb", {30'd0, bus.WB_FORWARD_EN}, 32'd2);

    // Newest producer wins
    do_reset();
    cycle(1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 9, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("newest_mem", {30'd0, bus.MEM_FORWARD_EN}, 32'd1);
    check_eq("newest_wb", {30'd0, bus.WB_FORWARD_EN}, 32'd0);

    // FLUSH beats load-use; next cycle stays in RUN with a bubble in EX
    do_reset();
    cycle(1'b1, 0, 0, 10, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 10, 0, 3, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("flush_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("flush_fwd", {28'd0, bus.MEM_FORWARD_EN, bus.WB_FORWARD_EN}, 32'd0);
    cycle(1'b1, 10, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("flush_after_wb", {30'd0, bus.WB_FORWARD_EN}, 32'd1);

    // x0 producers never forward or stall
    cycle(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("x0_stall", {31'd0, obs_stall}, 32'd0);
    cycle(1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("x0_fwd", {28'd0, bus.MEM_FORWARD_EN, bus.WB_FORWARD_EN}, 32'd0);

    // Reset while a load-use hazard is pending, and reset during BUBBLE
    do_reset();
    cycle(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_stall", {31'd0, obs_stall}, 32'd0);
    cycle(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_bubble_cnt", {16'd0, bus.STALL_COUNT}, 32'd0);
    check_eq("rst_bubble_fwd", {28'd0, bus.MEM_FORWARD_EN, bus.WB_FORWARD_EN}, 32'd0);

    // Saturation: preload near the top, then keep stalling past 0xFFFF
    do_reset();
    m_cnt = 65520;
    force dut.stall_count_d = 16'hFFF0;
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    release dut.stall_count_d;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 0, 0, 11, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 11, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 11, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    check_eq("sat_count", {16'd0, bus.STALL_COUNT}, 32'h0000FFFF);

    // Random instruction streams over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 8,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
